// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns byte-addressed CPU loads/stores into word beats over valid/ready.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: unaligned word accesses return an error instead of truncating.
module mem_access_unit #(
  parameter int ADDR_W  = 18,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             byte_q;
  logic             signed_q;
  logic [1:0]       lane_q;
  logic [7:0]       wbyte_q;
  logic             range_err;
  logic             misalign;

  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic is_byte,
                                           input logic is_signed, input logic [1:0] lane);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = word[{lane, 3'b000} +: 8];
    sx = 32'(sb);
    if (!is_byte)
      return word;
    else if (is_signed)
      return sx;
    else
      return {24'd0, sb};
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    logic [31:0] r;
    r = word;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Any set bit above the word-index field addresses memory that does not exist.
  assign range_err = (req_addr >> (ADDR_W + 2)) != 32'd0;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign misalign = !req_byte && (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      wait_cnt   <= '0;
      byte_q     <= 1'b0;
      signed_q   <= 1'b0;
      lane_q     <= 2'd0;
      wbyte_q    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            byte_q    <= req_byte;
            signed_q  <= req_signed;
            lane_q    <= req_addr[1:0];
            wbyte_q   <= req_wdata[7:0];
            wait_cnt  <= '0;
            mem_addr  <= req_addr[ADDR_W+1:2];
            if (range_err || misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              mem_valid <= 1'b1;
              mem_we    <= req_we && !req_byte;
              if (req_we && !req_byte)
                mem_wdata <= req_wdata;
              if (!req_we)
                state <= RD;
              else if (req_byte)
                state <= RMW_RD;
              else
                state <= WR;
            end
          end
        end

        RD, WR, RMW_RD, RMW_WR: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state == RMW_RD) begin
              // Second beat of the read-modify-write starts immediately.
              mem_we    <= 1'b1;
              mem_wdata <= merge_byte(mem_rdata, lane_q, wbyte_q);
              state     <= RMW_WR;
            end else begin
              mem_valid  <= 1'b0;
              mem_we     <= 1'b0;
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= (state == RD) ? fmt_load(mem_rdata, byte_q, signed_q, lane_q) : 32'd0;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a memory model checks each beat, a monitor checks each response.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  mem_access_unit #(.ADDR_W(18), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] rdata;
    int          delay;
  } beat_t;

  resp_t exp_q[$];
  beat_t beat_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_acc = 0;
  logic  idle_noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: answers beats from beat_q and checks the beat fields every cycle of the beat.
  initial begin
    int bw = 0;
    beat_t b;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", {31'd0, mem_valid}, 32'd0);
          mem_ready = 1'b0;
        end else begin
          b = beat_q[0];
          check("beat_we", {31'd0, mem_we}, {31'd0, b.we});
          check("beat_addr", {14'd0, mem_addr}, {14'd0, b.addr});
          if (b.chk_wdata) check("beat_wdata", mem_wdata, b.wdata);
          if (b.delay >= 0 && bw >= b.delay) begin
            mem_ready = 1'b1;
            mem_rdata = b.rdata;
            void'(beat_q.pop_front());
            bw = 0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            bw++;
          end
        end
      end else begin
        mem_ready = idle_noise;
        mem_rdata = 32'hBAD0_BAD0;
        bw = 0;
      end
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("resp_latency", cyc - e.acc + 1, e.lat);
          check("resp_req_ready", {31'd0, req_ready}, 32'd0);
          check("resp_mem_valid", {31'd0, mem_valid}, 32'd0);
        end
      end
    end
  end

  task automatic push_beat(input logic we, input logic [17:0] addr, input logic [31:0] wdata,
                           input logic chk, input logic [31:0] rdata, input int delay);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata; b.chk_wdata = chk; b.rdata = rdata; b.delay = delay;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic we, input logic byt, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input logic want_resp);
    int w = 0;
    resp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (want_resp) begin
      e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = last_acc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {14'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  initial begin
    int first_acc;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store, immediate ready.
    push_beat(1'b1, 18'd4, 32'hDEAD_BEEF, 1'b1, 32'd0, 0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1'b1);
    drain();

    // Byte loads from lane 3, signed then unsigned.
    push_beat(1'b0, 18'd4, 32'd0, 1'b0, 32'h80FF_0000, 0);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 1'b1);
    drain();
    push_beat(1'b0, 18'd4, 32'd0, 1'b0, 32'h80FF_0000, 0);
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'd0, 32'h0000_0080, 1'b0, 2, 1'b1);
    drain();

    // Byte loads from lanes 0 and 2; stray mem_ready while idle must be ignored.
    idle_noise = 1'b1;
    push_beat(1'b0, 18'h10, 32'd0, 1'b0, 32'hAABB_CC7F, 0);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'd0, 32'h0000_007F, 1'b0, 2, 1'b1);
    drain();
    push_beat(1'b0, 18'h10, 32'd0, 1'b0, 32'h00C3_0000, 1);
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'd0, 32'h0000_00C3, 1'b0, 3, 1'b1);
    drain();
    idle_noise = 1'b0;

    // Byte store read-modify-write, immediate ready.
    push_beat(1'b0, 18'd8, 32'd0, 1'b0, 32'h1122_3344, 0);
    push_beat(1'b1, 18'd8, 32'h1122_AB44, 1'b1, 32'd0, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0021, 32'h0000_00AB, 32'd0, 1'b0, 3, 1'b1);
    drain();

    // Byte store with waits on both beats; upper store data must not leak in.
    push_beat(1'b0, 18'd0, 32'd0, 1'b0, 32'h0102_0304, 2);
    push_beat(1'b1, 18'd0, 32'hEE02_0304, 1'b1, 32'd0, 1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'hFFFF_FFEE, 32'd0, 1'b0, 6, 1'b1);
    drain();

    // Word load at the top word index with waits, then an unaligned word load (truncated).
    push_beat(1'b0, 18'h3FFFF, 32'd0, 1'b0, 32'h1234_5678, 3);
    issue(1'b0, 1'b0, 1'b1, 32'h000F_FFFC, 32'd0, 32'h1234_5678, 1'b0, 5, 1'b1);
    drain();
    push_beat(1'b0, 18'h41, 32'd0, 1'b0, 32'hCAFE_F00D, 0);
    issue(1'b0, 1'b0, 1'b0, 32'h0000_0106, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);
    drain();

    // Range errors: no beat, response one cycle after acceptance.
    issue(1'b0, 1'b0, 1'b0, 32'h0010_0000, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    drain();
    issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 32'd0, 1'b1, 1, 1'b1);
    drain();

    // Request presented during RESP is accepted one cycle later.
    issue(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    first_acc = last_acc;
    push_beat(1'b1, 18'd5, 32'h0BAD_CAFE, 1'b1, 32'd0, 0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h0BAD_CAFE, 32'd0, 1'b0, 2, 1'b1);
    check("back_to_back_accept", last_acc - first_acc, 32'd2);
    drain();

    // Timeouts: word load, then byte store stalled in its read beat (no write may follow).
    push_beat(1'b0, 18'd7, 32'd0, 1'b0, 32'd0, -1);
    issue(1'b0, 1'b0, 1'b0, 32'h0000_001C, 32'd0, 32'd0, 1'b1, 65, 1'b1);
    drain();
    beat_q.delete();
    check("timeout_req_ready", {31'd0, req_ready}, 32'd1);
    push_beat(1'b0, 18'd9, 32'd0, 1'b0, 32'd0, -1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0025, 32'h0000_0077, 32'd0, 1'b1, 65, 1'b1);
    drain();
    beat_q.delete();
    repeat (5) @(negedge clk);

    // Reset while a read-modify-write read beat is waiting.
    push_beat(1'b0, 18'd12, 32'd0, 1'b0, 32'd0, -1);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0031, 32'h0000_0099, 32'd0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_mem_valid", {31'd0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    beat_q.delete();
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Normal operation after reset.
    push_beat(1'b0, 18'd12, 32'd0, 1'b0, 32'h5A5A_A5A5, 0);
    issue(1'b0, 1'b1, 1'b1, 32'h0000_0031, 32'd0, 32'hFFFF_FFA5, 1'b0, 2, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU memory stage and the word-addressed data memory.
- Accepts one byte-addressed load or store at a time from the CPU and turns it into word-granular memory transactions over a valid/ready handshake.
- Byte loads use lane extraction with sign or zero extension. Byte stores use a read-modify-write sequence.
- Returns a single-cycle response pulse to the CPU, with an error flag for out-of-range addresses and memory timeouts.

Parameters:
- ADDR_W, 18, width of the memory word index.
- TIMEOUT, 64, maximum cycles to wait for mem_ready per memory beat before aborting; must be ≥2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_byte  in  1  1=byte access, 0=word access
- req_signed  in  1  byte load sign-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data (byte store uses [7:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, valid with resp_valid
- resp_err  out  1  error flag, valid with resp_valid
- mem_valid  out  1  memory beat request
- mem_we  out  1  memory beat is a write
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read word, sampled when mem_ready=1
- mem_ready  in  1  memory completes the current beat

Behaviour:
- Reset (async, rst_n=0): state=IDLE. req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_valid=0; mem_we=0; mem_addr=0; mem_wdata=0; timeout counter=0.
- Address split:
  - word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0]; lane 0 = bits [7:0], little-endian.
  - req_addr[31:ADDR_W+2] nonzero → range error.
  - Word access ignores req_addr[1:0] (word-aligned by truncation).
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. When req_valid=1, latch all request fields.
  - Range error → RESP with err=1.
  - Word load → RD. Word store → WR.
  - Byte load → RD. Byte store → RMW_RD.
- RD, RMW_RD: mem_valid=1, mem_we=0.
  - On mem_ready, capture mem_rdata.
  - RD → RESP with the result formatted.
  - RMW_RD → RMW_WR. mem_wdata = captured word with the lane byte replaced by req_wdata[7:0].
- WR, RMW_WR: mem_valid=1, mem_we=1, mem_addr and mem_wdata held stable. On mem_ready → RESP, rdata=0.
- RESP: resp_valid=1 for exactly one cycle; mem_valid=0; next state IDLE.
- Handshake rules:
  - req_ready is 1 only in IDLE.
  - mem_valid, mem_we, mem_addr and mem_wdata stay stable until mem_ready.
  - mem_ready outside a beat is ignored.
  - mem_valid drops the cycle after mem_ready.
- Load formatting:
  - Word load: rdata = word.
  - Byte load: byte = word[8*lane+7:8*lane]; sign-extend if req_signed, else zero-extend.
- Latency with mem_ready the first cycle mem_valid is high (request accepted at edge T):
  - Word load/store: resp_valid at T+2.
  - Byte store: resp_valid at T+3.
  - Each extra memory wait cycle adds 1.
- Timeout:
  - The counter resets at each beat start and increments each cycle mem_valid=1 && mem_ready=0.
  - Reaching TIMEOUT → drop mem_valid, go to RESP with err=1 and rdata=0.
  - A timeout in RMW_RD means no write is issued.
- Simultaneous events: resp_valid and a new req_valid in the same cycle → the request is not accepted (req_ready=0 in RESP); it is accepted the next cycle.
- Reset mid-operation: everything returns to reset values immediately; the pending beat is abandoned and no response is produced.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a word access with req_addr[1:0]≠0 issues no memory beat and goes directly to RESP with resp_err=1, rdata=0; response 1 cycle after acceptance.
- Undefined: the low address bits are truncated for word accesses, as above.

Test Plan:
- Word store addr 0x0000_0010, data 0xDEADBEEF, mem_ready immediate → one write beat: mem_addr=4, mem_wdata=0xDEADBEEF; resp_valid at T+2, err=0.
- Byte load signed addr 0x13, memory word 0x80FF_0000 → resp_rdata=0xFFFF_FF80. Same load unsigned → 0x0000_0080.
- Byte store addr 0x21, wdata 0xAB, memory word 0x1122_3344 → read beat, then write beat with mem_addr=8 and mem_wdata=0x1122_AB44; resp_valid at T+3.
- mem_ready held low with TIMEOUT=64 → mem_valid drops after 64 wait cycles; resp_valid with err=1, rdata=0; req_ready returns to 1.
- req_addr=0x0010_0000 (above the 18-bit word range) → no mem_valid; resp_valid at T+1 with err=1.
- rst_n low for 1 cycle while RMW_RD is waiting → mem_valid=0 and req_ready=1 immediately; no resp_valid and no write beat afterwards.
